step_ctrl: RTL and testbench
============================

# step_ctrl

Execution-enable controller for `procesadorArm`. It turns the raw step push-button and run/step select switch into a clean, cycle-accurate `cpu_en` qualifier for the processor datapath. Modes are free-run, or an N-cycle burst per debounced button press. A halt request from the core latches a halted state, and a retired-cycle counter is kept for debug and bench checking.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a button level change; must be ≥1.
- `BURST_W`, default 8: width of `burst_len`.
- `CNT_W`, default 32: width of `cycle_count`.

- `clk` in 1: single system clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `step_btn` in 1: raw, asynchronous step push-button; high = pressed.
- `run_sel` in 1: raw, asynchronous mode switch; 1 = free-run, 0 = step.
- `burst_len` in BURST_W: enabled cycles per accepted press; 0 is treated as 1. Sampled on the cycle the press is accepted.
- `halt_req` in 1: synchronous, from the core; high for ≥1 cycle requests halt.
- `cpu_en` out 1: datapath/PC update enable; Moore output of the state.
- `step_busy` out 1: high while in BURST.
- `halted` out 1: high in HALT.
- `cycle_count` out CNT_W: number of cycles with `cpu_en`=1; wraps modulo 2^CNT_W.

## Operation
- **Synchronizers.** `step_btn` and `run_sel` each pass through a 2-flop synchronizer, producing `btn_s` and `run_s`. Both reset to 0.
- **Debouncer.** Holds register `btn_db` and a counter.
  - Counter increments on each cycle where `btn_s` ≠ `btn_db`.
  - Counter clears on any cycle where `btn_s` = `btn_db`.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `btn_s` still differs, `btn_db` ← `btn_s` and the counter clears.
- **Press event.** `press` = `btn_db` & ~`btn_db_q` (rising edge), one cycle wide. The falling edge produces no event.
- **FSM states:** IDLE, RUN, BURST, HALT. Reset state is IDLE.
  - IDLE (`cpu_en`=0):
    - `halt_req` → HALT.
    - else `run_s` → RUN.
    - else `press` → BURST, with `remaining` ← max(`burst_len`,1).
  - RUN (`cpu_en`=1):
    - `halt_req` → HALT.
    - else !`run_s` → IDLE.
    - Presses are ignored.
  - BURST (`cpu_en`=1, `step_busy`=1):
    - `halt_req` → HALT.
    - else if `remaining`==1 → RUN if `run_s`, otherwise IDLE.
    - else `remaining` decrements.
    - Presses and `run_s` changes are ignored until exit.
  - HALT (`cpu_en`=0, `halted`=1): absorbing; exit only via `rst`.
- **Priority.** `halt_req` beats every other transition in the same cycle.
- **Cycle counter.** `cycle_count` increments at every edge where `cpu_en`=1 (current state), so it counts exactly the cycles the core advanced.

## Timing
- **Reset values:** `cpu_en`=0, `step_busy`=0, `halted`=0, `cycle_count`=0. Internal: `btn_db`=0, `btn_db_q`=0, `remaining`=0, debounce counter=0.
- **`rst` assertion** forces these values immediately, with no clock needed. This applies mid-burst or mid-run; the burst is abandoned and no partial count is retained.
- **Release** takes effect on the first rising edge with `rst`=1.
- **Button-to-enable latency.** Take the edge that first samples `step_btn`=1 as edge 1.
  - `btn_s` is high after edge 2.
  - `btn_db` rises after edge 2+`DEBOUNCE_CYCLES`.
  - The state enters BURST after edge 3+`DEBOUNCE_CYCLES`.
  - `cpu_en` is high for the following `max(burst_len,1)` cycles exactly.
- **Glitches.** A pulse on `step_btn` lasting fewer than `DEBOUNCE_CYCLES` synchronized cycles produces no press.
- **`run_sel` latency.** A change reaches `run_s` after 2 edges. The state changes on the next edge (IDLE↔RUN only).
- **`halt_req` latency.** If `halt_req` is high during a cycle with `cpu_en`=1, that cycle is still counted. `cpu_en` is 0 from the next cycle onward.
- **Holding the button** produces exactly one burst; a new burst needs a release, then a press, each debounced.
- **Counter wrap:** all-ones + 1 = 0; no flag.

## Test plan
1. **Reset.** Drive `rst`=0 asynchronously mid-cycle. → All outputs go to 0 immediately. After release, the state is IDLE and `cpu_en`=0 for 20 cycles with inputs idle.
2. **Single step.** `DEBOUNCE_CYCLES`=4, `burst_len`=0, hold `step_btn` high for 10 cycles. → `cpu_en`=1 for exactly 1 cycle, starting after edge 7. `cycle_count`=1.
3. **Burst and glitch.** `burst_len`=5, press held 10 cycles. → 5 consecutive `cpu_en` cycles and `cycle_count`=5. Then a 3-cycle `step_btn` glitch → no further enable; `cycle_count` stays 5.
4. **Free-run.** `run_sel`=1 for 50 cycles. → `cpu_en`=1 starting 3 edges after the change. After `run_sel`=0, `cpu_en` drops 3 edges later. `cycle_count` equals the number of enabled cycles (50).
5. **Halt.** Pulse `halt_req` for 1 cycle at burst cycle 2 of 5. → `cpu_en`=0 next cycle, `halted`=1, `cycle_count`=2. Later presses and `run_sel`=1 have no effect until `rst`.
6. **Mode change mid-burst.** `burst_len`=4, then set `run_sel`=1 during the burst. → The burst completes 4 cycles, then moves straight to RUN with no `cpu_en` gap.

Source files
------------

// File: rtl/step_ctrl.sv
// step_ctrl: execution-enable controller for the procesadorArm datapath.
// Turns a raw step push-button and run/step switch into a clean cpu_en
// qualifier: free-run, or an N-cycle burst per debounced press. A halt
// request from the core parks the controller until reset. cycle_count
// tracks the number of cycles the core was enabled.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | core stopped, waiting for run mode, a press or a halt
// S_RUN   | free-running, cpu_en held high while run_s stays high
// S_BURST | stepping, cpu_en high for 'remaining' more cycles
// S_HALT  | core requested halt; absorbing until reset
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BURST_W         = 8,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_btn,
  input  logic               run_sel,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  output logic               cpu_en,
  output logic               step_busy,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               btn_meta_q, btn_meta_d;
  logic               btn_s_q, btn_s_d;
  logic               run_meta_q, run_meta_d;
  logic               run_s_q, run_s_d;
  logic               btn_db_q, btn_db_d;
  logic               btn_db_prev_q, btn_db_prev_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               press;

  // Synchronizer chains and debouncer: btn_db only follows btn_s after it
  // has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    btn_meta_d    = step_btn;
    btn_s_d       = btn_meta_q;
    run_meta_d    = run_sel;
    run_s_d       = run_meta_q;
    btn_db_d      = btn_db_q;
    btn_db_prev_d = btn_db_q;
    db_cnt_d      = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign press = btn_db_q & ~btn_db_prev_q;

  // Input conditioning registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      run_meta_q    <= 1'b0;
      run_s_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      btn_meta_q    <= btn_meta_d;
      btn_s_q       <= btn_s_d;
      run_meta_q    <= run_meta_d;
      run_s_q       <= run_s_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      db_cnt_q      <= db_cnt_d;
    end
  end

  // Next-state and Moore outputs; halt_req outranks every other transition.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cpu_en      = 1'b0;
    step_busy   = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (run_s_q) begin
          state_d = S_RUN;
        end else if (press) begin
          state_d     = S_BURST;
          remaining_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
        end
      end
      S_RUN: begin
        cpu_en = 1'b1;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (!run_s_q) begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        cpu_en    = 1'b1;
        step_busy = 1'b1;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (remaining_q == BURST_W'(1)) begin
          state_d = run_s_q ? S_RUN : S_IDLE;
        end else begin
          remaining_d = remaining_q - BURST_W'(1);
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired-cycle counter: one count per enabled cycle, wrapping freely.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (cpu_en) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  // FSM, burst down-counter and cycle counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl. Expected enable windows are derived from the
// documented latencies (press accepted 3+DEBOUNCE_CYCLES edges after the
// first sampled high, run_sel 3 edges) and a running count of enabled cycles.
module tb_step_ctrl;

  localparam int DEB = 4;
  localparam int LAT = 3 + DEB;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step_btn = 1'b0;
  logic          run_sel = 1'b0;
  logic [7:0]    burst_len = 8'd0;
  logic          halt_req = 1'b0;
  logic          cpu_en;
  logic          step_busy;
  logic          halted;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BURST_W(8),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_btn(step_btn),
    .run_sel(run_sel),
    .burst_len(burst_len),
    .halt_req(halt_req),
    .cpu_en(cpu_en),
    .step_busy(step_busy),
    .halted(halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int eff_len(input int b);
    return (b == 0) ? 1 : b;
  endfunction

  task automatic test_reset();
    rst = 1'b0; step_btn = 1'b0; run_sel = 1'b0; halt_req = 1'b0; burst_len = 8'd0;
    #3;
    checks++;
    if ({cpu_en, step_busy, halted} !== 3'b000 || cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_initial: en/busy/halt=%b%b%b count=%0d, want 000 count=0", cpu_en, step_busy, halted, cycle_count);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (cpu_en !== 1'b0 || step_busy !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: en/busy/halt=%b%b%b, want 000", i, cpu_en, step_busy, halted);
      end
    end
    run_sel = 1'b1;
    tick(5);
    checks++;
    if (cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_run: cpu_en=%b, want 1", cpu_en);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_async_run: cpu_en=%b count=%0d, want 0 0", cpu_en, cycle_count);
    end
    run_sel = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick(4);
    burst_len = 8'd8;
    step_btn = 1'b1;
    tick(LAT + 1);
    checks++;
    if (step_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_burst: step_busy=%b, want 1", step_busy);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (step_busy !== 1'b0 || cpu_en !== 1'b0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_async_burst: busy=%b en=%b count=%0d, want 0 0 0", step_busy, cpu_en, cycle_count);
    end
    step_btn = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_resume cycle %0d: cpu_en=%b, want 0", i, cpu_en);
      end
    end
    checks++;
    if (cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_count: count=%0d, want 0", cycle_count);
    end
    exp_count = 0;
  endtask

  // Press held for 'hold' sampled cycles with the given burst length.
  task automatic test_burst(input int blen, input int hold, input string tag);
    int   eff;
    int   win;
    logic exp_en;
    eff = eff_len(blen);
    win = ((LAT + eff) > (hold + 2 + DEB) ? (LAT + eff) : (hold + 2 + DEB)) + 4;
    burst_len = 8'(blen);
    step_btn = 1'b1;
    for (int i = 1; i <= win; i++) begin
      tick();
      if (i == hold) step_btn = 1'b0;
      if (i == LAT) burst_len = 8'($urandom_range(255, 0));
      exp_en = (i >= LAT) && (i < LAT + eff);
      checks++;
      if (cpu_en !== exp_en || step_busy !== exp_en) begin
        errors++;
        $display("FAIL %s cycle %0d: en=%b busy=%b, want %b", tag, i, cpu_en, step_busy, exp_en);
      end
    end
    exp_count += eff;
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL %s count: got %0d, want %0d", tag, cycle_count, CW'(exp_count));
    end
  endtask

  task automatic test_glitch(input int g);
    step_btn = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == g) step_btn = 1'b0;
      checks++;
      if (cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL glitch_%0d cycle %0d: cpu_en=%b, want 0", g, i, cpu_en);
      end
    end
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL glitch_%0d count: got %0d, want %0d", g, cycle_count, CW'(exp_count));
    end
  endtask

  task automatic test_single_step();
    test_burst(0, 10, "single_step");
  endtask

  task automatic test_burst_glitch();
    test_burst(5, 10, "burst5");
    test_glitch(3);
    for (int r = 0; r < 3; r++) test_glitch(int'($urandom_range(DEB - 1, 1)));
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 8; r++) begin
      test_burst(int'($urandom_range(20, 0)), int'($urandom_range(30, DEB + 1)), "b2b");
    end
  endtask

  task automatic test_free_run(input int len, input string tag);
    logic exp_en;
    run_sel = 1'b1;
    for (int i = 1; i <= len + 6; i++) begin
      tick();
      if (i == len) run_sel = 1'b0;
      exp_en = (i >= 3) && (i <= len + 2);
      checks++;
      if (cpu_en !== exp_en || step_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: en=%b busy=%b, want %b 0", tag, i, cpu_en, step_busy, exp_en);
      end
    end
    exp_count += len;
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL %s count: got %0d, want %0d", tag, cycle_count, CW'(exp_count));
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL halt_release: halted=%b count=%0d, want 0 0", halted, cycle_count);
    end
    step_btn = 1'b0; run_sel = 1'b0; halt_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick(3);
    exp_count = 0;
  endtask

  // After a halt, presses and run mode must have no effect.
  task automatic check_lockout(input string tag);
    burst_len = 8'd3;
    step_btn = 1'b1;
    run_sel = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 10) step_btn = 1'b0;
      checks++;
      if (cpu_en !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL %s_lock cycle %0d: en=%b halted=%b, want 0 1", tag, i, cpu_en, halted);
      end
    end
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL %s_lock count: got %0d, want %0d", tag, cycle_count, CW'(exp_count));
    end
    reset_pulse();
  endtask

  // Halt pulsed during the k-th enabled cycle of a burst.
  task automatic test_halt_burst(input int blen, input int k);
    logic exp_en;
    logic exp_halt;
    burst_len = 8'(blen);
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) step_btn = 1'b0;
      halt_req = (i == LAT + k - 1);
      exp_en = (i >= LAT) && (i < LAT + k);
      exp_halt = (i >= LAT + k);
      checks++;
      if (cpu_en !== exp_en || halted !== exp_halt) begin
        errors++;
        $display("FAIL halt_burst_%0d_%0d cycle %0d: en=%b halted=%b, want %b %b", blen, k, i, cpu_en, halted, exp_en, exp_halt);
      end
    end
    halt_req = 1'b0;
    exp_count += k;
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL halt_burst count: got %0d, want %0d", cycle_count, CW'(exp_count));
    end
    check_lockout("halt_burst");
  endtask

  task automatic test_halt_run(input int m);
    logic exp_en;
    run_sel = 1'b1;
    for (int i = 1; i <= m + 8; i++) begin
      tick();
      halt_req = (i == m + 2);
      exp_en = (i >= 3) && (i < 3 + m);
      checks++;
      if (cpu_en !== exp_en || halted !== (i >= 3 + m)) begin
        errors++;
        $display("FAIL halt_run_%0d cycle %0d: en=%b halted=%b, want %b", m, i, cpu_en, halted, exp_en);
      end
    end
    halt_req = 1'b0;
    exp_count += m;
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL halt_run count: got %0d, want %0d", cycle_count, CW'(exp_count));
    end
    check_lockout("halt_run");
  endtask

  task automatic test_halt_idle();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++;
    if (halted !== 1'b1 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle: halted=%b en=%b, want 1 0", halted, cpu_en);
    end
    check_lockout("halt_idle");
  endtask

  // run_sel raised in the first burst cycle: burst runs out, then RUN with no gap.
  task automatic test_mode_change(input int blen);
    logic exp_en;
    logic exp_busy;
    burst_len = 8'(blen);
    step_btn = 1'b1;
    for (int i = 1; i <= LAT + 26; i++) begin
      tick();
      if (i == 10) step_btn = 1'b0;
      if (i == LAT) run_sel = 1'b1;
      if (i == LAT + 20) run_sel = 1'b0;
      exp_en = (i >= LAT) && (i <= LAT + 22);
      exp_busy = (i >= LAT) && (i < LAT + blen);
      checks++;
      if (cpu_en !== exp_en || step_busy !== exp_busy) begin
        errors++;
        $display("FAIL mode_change_%0d cycle %0d: en=%b busy=%b, want %b %b", blen, i, cpu_en, step_busy, exp_en, exp_busy);
      end
    end
    exp_count += 23;
    checks++;
    if (cycle_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL mode_change count: got %0d, want %0d", cycle_count, CW'(exp_count));
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_burst_glitch();
    test_free_run(50, "run50");
    for (int r = 0; r < 3; r++) test_free_run(int'($urandom_range(60, 1)), "run_rand");
    test_back_to_back();
    test_mode_change(4);
    test_mode_change(int'($urandom_range(12, 3)));
    test_halt_burst(5, 2);
    begin
      int b;
      b = int'($urandom_range(10, 1));
      test_halt_burst(b, int'($urandom_range(b, 1)));
    end
    test_halt_burst(0, 1);
    test_halt_run(int'($urandom_range(20, 1)));
    test_halt_idle();
    test_free_run(300, "wrap");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
